// File: rtl/bw_io_dtl_imp_upd_ctl.sv
// Impedance-code update sequencer for an 8-pad DTL bank: writes half 0, then half 1, only while the bank is quiet.
// Optional DTL_IMP_STEP_EN: each write moves the codes one LSB toward the target instead of jumping.
module bw_io_dtl_imp_upd_ctl #(
  parameter int         SETTLE_CYC = 4,
  parameter int         TMO_CYC    = 255,
  parameter logic [8:1] RST_CBU    = 8'h80,
  parameter logic [8:1] RST_CBD    = 8'h80
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cal_valid,
  input  logic [8:1] cal_cbu,
  input  logic [8:1] cal_cbd,
  output logic       cal_ack,
  input  logic       quiet,
  output logic [8:1] cbu0,
  output logic [8:1] cbd0,
  output logic [8:1] cbu1,
  output logic [8:1] cbd1,
  output logic       busy,
  output logic       imp_tmo
);
  typedef enum logic [2:0] {IDLE, WAITQ, UPD, SETTLE, ACK} state_t;

  state_t     state, state_nxt;
  logic       h, h_nxt;
  logic [7:0] wcnt, wcnt_nxt, scnt, scnt_nxt;
  logic [8:1] tgt_u, tgt_u_nxt, tgt_d, tgt_d_nxt;
  logic [8:1] cbu0_nxt, cbd0_nxt, cbu1_nxt, cbd1_nxt;
  logic       tmo_nxt;
  logic [8:1] sel_u, sel_d, new_u, new_d;
  logic       more;

  assign sel_u = h ? cbu1 : cbu0;
  assign sel_d = h ? cbd1 : cbd0;

`ifdef DTL_IMP_STEP_EN
  function automatic logic [8:1] step1(input logic [8:1] cur, input logic [8:1] tgt);
    if (cur < tgt) return cur + 8'd1;
    if (cur > tgt) return cur - 8'd1;
    return cur;
  endfunction
  assign new_u = step1(sel_u, tgt_u);
  assign new_d = step1(sel_d, tgt_d);
  // Evaluated in SETTLE, after the step has landed in the output registers.
  assign more  = (sel_u != tgt_u) || (sel_d != tgt_d);
`else
  assign new_u = tgt_u;
  assign new_d = tgt_d;
  assign more  = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    h_nxt     = h;
    wcnt_nxt  = wcnt;
    scnt_nxt  = scnt;
    tgt_u_nxt = tgt_u;
    tgt_d_nxt = tgt_d;
    tmo_nxt   = imp_tmo;
    cbu0_nxt  = cbu0;
    cbd0_nxt  = cbd0;
    cbu1_nxt  = cbu1;
    cbd1_nxt  = cbd1;
    case (state)
      IDLE: if (cal_valid) begin
        tgt_u_nxt = cal_cbu;
        tgt_d_nxt = cal_cbd;
        h_nxt     = 1'b0;
        tmo_nxt   = 1'b0;
        wcnt_nxt  = '0;
        if (cal_cbu == cbu0 && cal_cbu == cbu1 && cal_cbd == cbd0 && cal_cbd == cbd1)
          state_nxt = ACK;
        else
          state_nxt = WAITQ;
      end
      WAITQ: begin
        if (quiet) state_nxt = UPD;
        // Compare the incremented count in 9 bits so TMO_CYC = 1 forces on the first wait cycle.
        else if (({1'b0, wcnt} + 9'd1) >= 9'(TMO_CYC - 1)) begin
          state_nxt = UPD;
          tmo_nxt   = 1'b1;
        end else wcnt_nxt = wcnt + 8'd1;
      end
      UPD: begin
        if (h) begin
          cbu1_nxt = new_u;
          cbd1_nxt = new_d;
        end else begin
          cbu0_nxt = new_u;
          cbd0_nxt = new_d;
        end
        scnt_nxt  = 8'(SETTLE_CYC - 1);
        state_nxt = SETTLE;
      end
      SETTLE: begin
        if (scnt != 8'd0) scnt_nxt = scnt - 8'd1;
        else if (more) begin
          wcnt_nxt  = '0;
          state_nxt = WAITQ;
        end else if (!h) begin
          h_nxt     = 1'b1;
          wcnt_nxt  = '0;
          state_nxt = WAITQ;
        end else state_nxt = ACK;
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      h       <= 1'b0;
      wcnt    <= '0;
      scnt    <= '0;
      tgt_u   <= RST_CBU;
      tgt_d   <= RST_CBD;
      cbu0    <= RST_CBU;
      cbd0    <= RST_CBD;
      cbu1    <= RST_CBU;
      cbd1    <= RST_CBD;
      cal_ack <= 1'b0;
      busy    <= 1'b0;
      imp_tmo <= 1'b0;
    end else begin
      state   <= state_nxt;
      h       <= h_nxt;
      wcnt    <= wcnt_nxt;
      scnt    <= scnt_nxt;
      tgt_u   <= tgt_u_nxt;
      tgt_d   <= tgt_d_nxt;
      cbu0    <= cbu0_nxt;
      cbd0    <= cbd0_nxt;
      cbu1    <= cbu1_nxt;
      cbd1    <= cbd1_nxt;
      cal_ack <= (state_nxt == ACK);
      busy    <= (state_nxt != IDLE);
      imp_tmo <= tmo_nxt;
    end
  end
endmodule
